// File: rtl/amci_arb_pkg.sv
// Shared types and constants for the AMCI requester arbiter.
package amci_arb_pkg;

  // Arbiter sequencing: grant, strobe, settle, wait for the master, guard cycle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Index width for n requesters, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/amci_rr_pick.sv
// Combinational winner selection for the AMCI arbiter.
// Default: round-robin starting at the slot after 'last'.
// AMCI_ARB_FIXED_PRI_EN: fixed priority, lowest index wins, 'last' ignored.
module amci_rr_pick
  import amci_arb_pkg::*;
#(
  parameter  int NREQ = 3,
  localparam int IW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            any,
  output logic [IW-1:0]   winner
);

  assign any = |req;

`ifdef AMCI_ARB_FIXED_PRI_EN
  logic unused_last_s;
  assign unused_last_s = ^last;

  // Lowest set index wins; scanning downward leaves the lowest one in place.
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      winner = req[i] ? IW'(i) : winner;
    end
  end
`else
  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;

  // Rotate so bit 0 is the requester right after the last winner.
  always_comb begin
    dbl_s = {req, req} >> (int'(last) + 1);
    rot_s = dbl_s[NREQ-1:0];
  end

  // First set bit of the rotated view, mapped back to a requester index.
  always_comb begin
    winner = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      winner = rot_s[j] ? IW'((int'(last) + 1 + j) % NREQ) : winner;
    end
  end
`endif

endmodule

// File: rtl/amci_arbiter.sv
// Shares the AMCI command port of axi4_lite_master between NREQ requesters,
// one transaction in flight at a time.
// Build option AMCI_ARB_FIXED_PRI_EN selects fixed priority instead of round-robin.
module amci_arbiter
  import amci_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0]               req_write,
  input  logic [NREQ*AW-1:0]            req_addr,
  input  logic [NREQ*DW-1:0]            req_wdata,
  output logic [NREQ-1:0]               rsp_valid,
  output logic [DW-1:0]                 rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [clog2_min1(NREQ)-1:0]   grant_id,
  output logic                          busy,
  output logic [AW-1:0]                 AMCI_WADDR,
  output logic [DW-1:0]                 AMCI_WDATA,
  output logic                          AMCI_WRITE,
  input  logic [1:0]                    AMCI_WRESP,
  input  logic                          AMCI_WIDLE,
  output logic [AW-1:0]                 AMCI_RADDR,
  output logic                          AMCI_READ,
  input  logic [DW-1:0]                 AMCI_RDATA,
  input  logic [1:0]                    AMCI_RRESP,
  input  logic                          AMCI_RIDLE
);

  localparam int IW = clog2_min1(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic            write_r;
  logic [IW-1:0]   rr_last_s;
  logic            pick_any_s;
  logic [IW-1:0]   pick_winner_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_wdata_s;
  logic            sel_write_s;
  logic            wait_done_s;

  amci_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req_valid),
    .last   (rr_last_s),
    .any    (pick_any_s),
    .winner (pick_winner_s)
  );

  // Route the winning requester's command fields to the grant latches.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_write_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr_s  = (pick_winner_s == IW'(i)) ? req_addr[i*AW +: AW]  : sel_addr_s;
      sel_wdata_s = (pick_winner_s == IW'(i)) ? req_wdata[i*DW +: DW] : sel_wdata_s;
      sel_write_s = (pick_winner_s == IW'(i)) ? req_write[i]          : sel_write_s;
    end
  end

  // The master has finished when the idle flag of the granted direction is back high.
  always_comb begin
    if (state_r == WAIT) begin
      wait_done_s = write_r ? AMCI_WIDLE : AMCI_RIDLE;
    end else begin
      wait_done_s = 1'b0;
    end
  end

`ifdef AMCI_ARB_FIXED_PRI_EN
  assign rr_last_s = '0;
`else
  logic [IW-1:0] rr_last_r;
  assign rr_last_s = rr_last_r;

  // Remember the last served requester; reset value makes requester 0 first.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_r <= IW'(NREQ - 1);
    end else if (wait_done_s) begin
      rr_last_r <= grant_id;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end
`endif

  // Transaction sequencer with registered response and AMCI drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      write_r    <= 1'b0;
      grant_id   <= '0;
      busy       <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_resp   <= RESP_OKAY;
      AMCI_WRITE <= 1'b0;
      AMCI_READ  <= 1'b0;
      AMCI_WADDR <= '0;
      AMCI_WDATA <= '0;
      AMCI_RADDR <= '0;
    end else begin
      rsp_valid  <= '0;
      AMCI_WRITE <= 1'b0;
      AMCI_READ  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            grant_id <= pick_winner_s;
            busy     <= 1'b1;
            write_r  <= sel_write_s;
            if (sel_write_s) begin
              AMCI_WADDR <= sel_addr_s;
              AMCI_WDATA <= sel_wdata_s;
            end else begin
              AMCI_RADDR <= sel_addr_s;
            end
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          AMCI_WRITE <= write_r;
          AMCI_READ  <= ~write_r;
          state_r    <= SETTLE;
        end
        SETTLE: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (wait_done_s) begin
            rsp_valid <= ONE_HOT0 << grant_id;
            rsp_rdata <= write_r ? '0 : AMCI_RDATA;
            rsp_resp  <= write_r ? AMCI_WRESP : AMCI_RRESP;
            state_r   <= DONE;
          end else begin
            state_r <= WAIT;
          end
        end
        DONE: begin
          // Guard cycle: the served requester is still dropping its req_valid.
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
